vga_frame_signature: RTL and testbench

- Synthesisable on-chip frame checker sitting beside vga_sync/graphics; replaces offline image dumping with a per-frame hardware signature.
- Monitors the pixel stream (pixel_x/pixel_y/video_on plus RGB) and folds every visible pixel into a CRC-32.
- At end of frame, publishes the signature, pixel count, frame index and an error flag.
- Generalised over resolution and colour depth; detects short, long and truncated frames.

---
 rtl/vga_sig_pkg.sv | 16 +
 rtl/vga_frame_signature_if.sv | 52 +++++
 rtl/vga_crc_update.sv | 27 ++
 rtl/vga_frame_signature.sv | 158 +++++++++++++++
 tb/tb_vga_frame_signature.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_sig_pkg.sv
// Shared constants and state encoding for the VGA frame signature checker.
package vga_sig_pkg;

    localparam int unsigned CRC_W = 32;

    // CRC-32 polynomial, MSB-first, all-ones preset, no reflection, no final XOR.
    localparam logic [CRC_W-1:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [CRC_W-1:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        PUBLISH = 2'd2
    } sig_state_e;

endpackage

// File: rtl/vga_frame_signature_if.sv
// Pixel stream in / frame signature out bundle for vga_frame_signature.
// Optional macro VGA_SIG_COMPARE_EN adds expected_sig, match and mismatch_sticky.
interface vga_frame_signature_if
    import vga_sig_pkg::*;
#(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned FCNT_W  = 16
);

    logic                   pix_en;
    logic                   video_on;
    logic [COORD_W-1:0]     pixel_x;
    logic [COORD_W-1:0]     pixel_y;
    logic [COLOR_W-1:0]     graph_r;
    logic [COLOR_W-1:0]     graph_g;
    logic [COLOR_W-1:0]     graph_b;

    logic [CRC_W-1:0]       sig;
    logic                   sig_valid;
    logic [2*COORD_W-1:0]   pix_count;
    logic [FCNT_W-1:0]      frame_count;
    logic                   frame_error;
    logic                   busy;

`ifdef VGA_SIG_COMPARE_EN
    logic [CRC_W-1:0]       expected_sig;
    logic                   match;
    logic                   mismatch_sticky;

    modport master (
        output pix_en, video_on, pixel_x, pixel_y, graph_r, graph_g, graph_b, expected_sig,
        input  sig, sig_valid, pix_count, frame_count, frame_error, busy, match, mismatch_sticky
    );

    modport slave (
        input  pix_en, video_on, pixel_x, pixel_y, graph_r, graph_g, graph_b, expected_sig,
        output sig, sig_valid, pix_count, frame_count, frame_error, busy, match, mismatch_sticky
    );
`else
    modport master (
        output pix_en, video_on, pixel_x, pixel_y, graph_r, graph_g, graph_b,
        input  sig, sig_valid, pix_count, frame_count, frame_error, busy
    );

    modport slave (
        input  pix_en, video_on, pixel_x, pixel_y, graph_r, graph_g, graph_b,
        output sig, sig_valid, pix_count, frame_count, frame_error, busy
    );
`endif

endinterface

// File: rtl/vga_crc_update.sv
// One-step CRC-32 update over a DATA_W-bit word, MSB of the word shifted in first.
module vga_crc_update
    import vga_sig_pkg::*;
#(
    parameter int unsigned DATA_W = 24
) (
    input  logic [CRC_W-1:0]  crc,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  next_crc
);

    logic [CRC_W-1:0] acc;

    // Bit-serial LFSR unrolled across the whole data word.
    always_comb begin
        acc = crc;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (acc[CRC_W-1] ^ data[DATA_W-1-i]) begin
                acc = {acc[CRC_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                acc = {acc[CRC_W-2:0], 1'b0};
            end
        end
        next_crc = acc;
    end

endmodule

// File: rtl/vga_frame_signature.sv
// Per-frame CRC-32 signature of the visible pixel stream, with pixel count,
// frame index and malformed-frame flag published at end of frame.
// Optional macro VGA_SIG_COMPARE_EN adds a comparison against expected_sig.
module vga_frame_signature
    import vga_sig_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned COLOR_W  = 8,
    parameter int unsigned FCNT_W   = 16
) (
    input  logic                  clock_50,
    input  logic                  reset_key,
    vga_frame_signature_if.slave  bus
);

    localparam int unsigned CNT_W  = 2 * COORD_W;
    localparam int unsigned DATA_W = 3 * COLOR_W;

    localparam logic [COORD_W-1:0] H_LIM     = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_LIM     = COORD_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]   FRAME_PIX = CNT_W'(H_ACTIVE * V_ACTIVE);

    sig_state_e          state_q, state_d;
    logic [CRC_W-1:0]    crc_q, crc_d, crc_base, crc_next;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                qual, sof, eof;
    logic                publish, pub_err;

    logic [CRC_W-1:0]    sig_q;
    logic                sig_valid_q;
    logic [CNT_W-1:0]    pix_count_q;
    logic [FCNT_W-1:0]   frame_count_q;
    logic                frame_error_q;
    logic                busy_q;

    // Pixel qualification and frame boundary detection.
    assign qual = bus.pix_en & bus.video_on & (bus.pixel_x < H_LIM) & (bus.pixel_y < V_LIM);
    assign sof  = qual & (bus.pixel_x == '0) & (bus.pixel_y == '0);
    assign eof  = bus.pix_en & (bus.pixel_y >= V_LIM);

    // A start-of-frame pixel always folds into a fresh preset, never the old residue.
    assign crc_base = sof ? CRC_INIT : crc_q;

    vga_crc_update #(
        .DATA_W (DATA_W)
    ) u_crc (
        .crc      (crc_base),
        .data     ({bus.graph_r, bus.graph_g, bus.graph_b}),
        .next_crc (crc_next)
    );

    // State register.
    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, accumulator update and publish decision.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        count_d = count_q;
        publish = 1'b0;
        pub_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (sof) begin
                    crc_d   = crc_next;
                    count_d = CNT_W'(1);
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sof) begin
                    // Missing blanking: report the truncated frame and restart on this pixel.
                    publish = 1'b1;
                    pub_err = 1'b1;
                    crc_d   = crc_next;
                    count_d = CNT_W'(1);
                end else if (qual) begin
                    crc_d = crc_next;
                    if (count_q != '1) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else if (eof) begin
                    publish = 1'b1;
                    pub_err = (count_q != FRAME_PIX);
                    state_d = PUBLISH;
                end
            end
            PUBLISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Accumulator and published result registers.
    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            crc_q         <= CRC_INIT;
            count_q       <= '0;
            sig_q         <= '0;
            sig_valid_q   <= 1'b0;
            pix_count_q   <= '0;
            frame_count_q <= '0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            crc_q       <= crc_d;
            count_q     <= count_d;
            sig_valid_q <= publish;
            busy_q      <= (state_d == ACTIVE);
            if (publish) begin
                sig_q         <= crc_q;
                pix_count_q   <= count_q;
                frame_error_q <= pub_err;
                frame_count_q <= frame_count_q + FCNT_W'(1);
            end
        end
    end

    assign bus.sig         = sig_q;
    assign bus.sig_valid   = sig_valid_q;
    assign bus.pix_count   = pix_count_q;
    assign bus.frame_count = frame_count_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = busy_q;

`ifdef VGA_SIG_COMPARE_EN
    logic match_q;
    logic mismatch_sticky_q;

    // Golden-signature comparison, updated alongside each publish.
    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            match_q           <= 1'b0;
            mismatch_sticky_q <= 1'b0;
        end else if (publish) begin
            match_q <= (crc_q == bus.expected_sig);
            if (crc_q != bus.expected_sig) begin
                mismatch_sticky_q <= 1'b1;
            end
        end
    end

    assign bus.match           = match_q;
    assign bus.mismatch_sticky = mismatch_sticky_q;
`endif

endmodule

// File: tb/tb_vga_frame_signature.sv
// Directed bench for vga_frame_signature on a 4x2 visible area.
module tb_vga_frame_signature;

    localparam int unsigned H  = 4;
    localparam int unsigned V  = 2;
    localparam int unsigned CW = 10;
    localparam int unsigned KW = 8;
    localparam int unsigned FW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vga_frame_signature_if #(.COORD_W(CW), .COLOR_W(KW), .FCNT_W(FW)) bus ();

    vga_frame_signature #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .COORD_W  (CW),
        .COLOR_W  (KW),
        .FCNT_W   (FW)
    ) dut (
        .clock_50  (clk),
        .reset_key (rst_n),
        .bus       (bus)
    );

    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          pulses = 0;
    logic [31:0] model_crc;
    int          model_cnt;
    logic [31:0] sig_a;
    logic [31:0] exp5;
    int          p0;

    always @(posedge clk) if (bus.sig_valid) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte-at-a-time CRC-32 reference, MSB-first, no reflection, no final XOR.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {d, 24'h0};
        for (int k = 0; k < 8; k++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        return r;
    endfunction

    // Pattern 0: all zero. Pattern 1: r=x, g=y, b=A5, optional +1 on r at (2,1).
    function automatic logic [23:0] pix_rgb(input int p, input bit corrupt, input int x, input int y);
        logic [7:0] r, g, b;
        if (p == 0) begin
            r = 8'h00; g = 8'h00; b = 8'h00;
        end else begin
            r = 8'(x); g = 8'(y); b = 8'hA5;
            if (corrupt && x == 2 && y == 1) r = r + 8'd1;
        end
        return {r, g, b};
    endfunction

    function automatic logic [31:0] frame_crc(input int p, input bit corrupt);
        logic [31:0] c;
        logic [23:0] w;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < int'(H * V); i++) begin
            w = pix_rgb(p, corrupt, i % int'(H), i / int'(H));
            c = crc_byte(crc_byte(crc_byte(c, w[23:16]), w[15:8]), w[7:0]);
        end
        return c;
    endfunction

    task automatic pix(input logic en, input logic vo, input int x, input int y,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bus.pix_en   = en;
        bus.video_on = vo;
        bus.pixel_x  = CW'(x);
        bus.pixel_y  = CW'(y);
        bus.graph_r  = r;
        bus.graph_g  = g;
        bus.graph_b  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 0, 0, 8'h00, 8'h00, 8'h00);
    endtask

    // Raster pixels first..first+n-1; the reference restarts at pixel 0.
    task automatic send_pixels(input int first, input int n, input int p, input bit corrupt);
        logic [23:0] w;
        int x, y;
        for (int i = first; i < first + n; i++) begin
            if (i == 0) begin
                model_crc = 32'hFFFFFFFF;
                model_cnt = 0;
            end
            x = i % int'(H);
            y = i / int'(H);
            w = pix_rgb(p, corrupt, x, y);
            model_crc = crc_byte(crc_byte(crc_byte(model_crc, w[23:16]), w[15:8]), w[7:0]);
            model_cnt++;
            pix(1'b1, 1'b1, x, y, w[23:16], w[15:8], w[7:0]);
        end
    endtask

    task automatic end_frame(input string tag);
        check({tag, "_pre_valid"}, 32'(bus.sig_valid), 0);
        pix(1'b1, 1'b0, 0, int'(V), 8'h00, 8'h00, 8'h00);
    endtask

    task automatic check_pub(input string tag, input logic [31:0] s, input int cnt,
                             input int err, input int fc);
        check({tag, "_valid"}, 32'(bus.sig_valid), 1);
        check({tag, "_sig"}, bus.sig, s);
        check({tag, "_count"}, 32'(bus.pix_count), 32'(cnt));
        check({tag, "_err"}, 32'(bus.frame_error), 32'(err));
        check({tag, "_fcnt"}, 32'(bus.frame_count), 32'(fc));
    endtask

    task automatic full_frame(input string tag, input int p, input bit corrupt, input int fc);
        send_pixels(0, int'(H * V), p, corrupt);
        end_frame(tag);
        check_pub(tag, model_crc, model_cnt, 0, fc);
        idle(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.pix_en   = 1'b0;
        bus.video_on = 1'b0;
        bus.pixel_x  = '0;
        bus.pixel_y  = '0;
        bus.graph_r  = '0;
        bus.graph_g  = '0;
        bus.graph_b  = '0;
`ifdef VGA_SIG_COMPARE_EN
        bus.expected_sig = '0;
`endif
        idle(2);
        check("rst_sig", bus.sig, 0);
        check("rst_valid", 32'(bus.sig_valid), 0);
        check("rst_count", 32'(bus.pix_count), 0);
        check("rst_fcnt", 32'(bus.frame_count), 0);
        check("rst_err", 32'(bus.frame_error), 0);
        check("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        idle(2);

        // All-zero frame, latency and hold behaviour.
        send_pixels(0, 1, 0, 1'b0);
        check("busy_active", 32'(bus.busy), 1);
        send_pixels(1, int'(H * V) - 1, 0, 1'b0);
        end_frame("zero");
        check_pub("zero", model_crc, 8, 0, 1);
        idle(1);
        check("valid_one_cycle", 32'(bus.sig_valid), 0);
        check("busy_idle", 32'(bus.busy), 0);
        check("sig_hold", bus.sig, model_crc);
        idle(2);

        // Two identical patterned frames, then a single-pixel corruption.
        do_reset();
        full_frame("pat1", 1, 1'b0, 1);
        sig_a = bus.sig;
        full_frame("pat2", 1, 1'b0, 2);
        check("pat_repeat", bus.sig, sig_a);
        full_frame("corrupt", 1, 1'b1, 3);
        check("corrupt_differs", 32'(bus.sig != sig_a), 1);

        // SOF after 5 pixels: truncated publish, then a clean frame.
        do_reset();
        send_pixels(0, 5, 1, 1'b0);
        exp5 = model_crc;
        send_pixels(0, 1, 1, 1'b0);
        check_pub("trunc", exp5, 5, 1, 1);
        check("trunc_busy", 32'(bus.busy), 1);
        send_pixels(1, int'(H * V) - 1, 1, 1'b0);
        end_frame("after_trunc");
        check_pub("after_trunc", model_crc, 8, 1 - 1, 2);
        idle(2);

        // Known CRC-32/MPEG-2 check value of "123456789" over three pixels, short frame.
        do_reset();
        pix(1'b1, 1'b1, 0, 0, 8'h31, 8'h32, 8'h33);
        pix(1'b1, 1'b1, 1, 0, 8'h34, 8'h35, 8'h36);
        pix(1'b1, 1'b1, 2, 0, 8'h37, 8'h38, 8'h39);
        end_frame("check_str");
        check_pub("check_str", 32'h0376E6E7, 3, 1, 1);
        idle(2);

        // Reset in the middle of a frame discards it without a publish.
        full_frame("pre_abort", 1, 1'b0, 2);
        send_pixels(0, 3, 1, 1'b0);
        bus.pixel_x = CW'(3);
        bus.graph_r = 8'd3;
        p0 = pulses;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_sig", bus.sig, 0);
        check("abort_count", 32'(bus.pix_count), 0);
        check("abort_fcnt", 32'(bus.frame_count), 0);
        check("abort_err", 32'(bus.frame_error), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_valid", 32'(bus.sig_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        check("abort_no_pulse", 32'(pulses), 32'(p0));
        full_frame("post_abort", 1, 1'b0, 1);

`ifdef VGA_SIG_COMPARE_EN
        // Golden comparison and sticky mismatch.
        do_reset();
        bus.expected_sig = frame_crc(1, 1'b0);
        full_frame("cmp_good", 1, 1'b0, 1);
        check("cmp_match1", 32'(bus.match), 1);
        check("cmp_sticky1", 32'(bus.mismatch_sticky), 0);
        full_frame("cmp_bad", 1, 1'b1, 2);
        check("cmp_match2", 32'(bus.match), 0);
        check("cmp_sticky2", 32'(bus.mismatch_sticky), 1);
        full_frame("cmp_good2", 1, 1'b0, 3);
        check("cmp_match3", 32'(bus.match), 1);
        check("cmp_sticky3", 32'(bus.mismatch_sticky), 1);
`else
        check("model_frame", frame_crc(1, 1'b0), sig_a);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
